// File: rtl/opb_master_bridge.sv
// Single-outstanding OPB master: turns a fabric command/response handshake into
// one OPB read or write, with retry and timeout handling.
module opb_master_bridge #(
   parameter int C_OPB_AWIDTH = 32,
   parameter int C_OPB_DWIDTH = 32,
   parameter int C_TIMEOUT    = 255,
   parameter int C_MAX_RETRY  = 4
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   // Command: accepted on a cycle where cmd_valid and cmd_ready are both high;
   // response: rsp_valid is a single-cycle pulse with no back-pressure.
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_rnw,
   input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
   input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
   input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
   output logic                        rsp_valid,
   output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
   output logic [1:0]                  rsp_status,
   output logic                        M_request,
   output logic                        M_busLock,
   output logic                        M_select,
   output logic                        M_RNW,
   output logic [0:C_OPB_AWIDTH-1]     M_ABus,
   output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
   output logic [0:C_OPB_DWIDTH-1]     M_DBus,
   output logic                        M_seqAddr,
   input  logic                        OPB_MGrant,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_xferAck,
   input  logic                        OPB_errAck,
   input  logic                        OPB_retry,
   input  logic                        OPB_timeout,
   output logic [1:0]                  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ERRACK  = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_RETRY   = 2'b11;

   state_t                      state_q, state_d;
   logic                        rnw_q;
   logic [0:C_OPB_AWIDTH-1]     addr_q;
   logic [0:C_OPB_DWIDTH-1]     wdata_q;
   logic [0:C_OPB_DWIDTH/8-1]   be_q;
   logic [7:0]                  tmo_cnt_q, tmo_cnt_d;
   logic [3:0]                  rty_cnt_q, rty_cnt_d;
   logic                        load_cmd;
   logic                        load_rsp;
   logic [1:0]                  status_d;
   logic [0:C_OPB_DWIDTH-1]     rdata_d;

   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      rty_cnt_d = rty_cnt_q;
      load_cmd  = 1'b0;
      load_rsp  = 1'b0;
      status_d  = ST_OK;
      rdata_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               load_cmd  = 1'b1;
               rty_cnt_d = '0;
               tmo_cnt_d = '0;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            tmo_cnt_d = '0;
            if (OPB_MGrant) state_d = S_XFER;
         end
         S_XFER: begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            // Termination priority: xferAck, errAck, retry, then timeout.
            if (OPB_xferAck) begin
               load_rsp = 1'b1;
               status_d = OPB_errAck ? ST_ERRACK : ST_OK;
               rdata_d  = (rnw_q && !OPB_errAck) ? OPB_DBus : '0;
               state_d  = S_RESP;
            end else if (OPB_errAck) begin
               load_rsp = 1'b1;
               status_d = ST_ERRACK;
               state_d  = S_RESP;
            end else if (OPB_retry) begin
               if (({1'b0, rty_cnt_q} + 5'd1) < 5'(C_MAX_RETRY)) begin
                  rty_cnt_d = rty_cnt_q + 4'd1;
                  tmo_cnt_d = '0;
                  state_d   = S_REQ;
               end else begin
                  load_rsp = 1'b1;
                  status_d = ST_RETRY;
                  state_d  = S_RESP;
               end
            end else if (OPB_timeout || (tmo_cnt_q == 8'(C_TIMEOUT - 1))) begin
               load_rsp = 1'b1;
               status_d = ST_TIMEOUT;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q   <= S_IDLE;
         tmo_cnt_q <= '0;
         rty_cnt_q <= '0;
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         rty_cnt_q <= rty_cnt_d;
         if (load_cmd) begin
            rnw_q   <= cmd_rnw;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            be_q    <= cmd_be;
         end
      end
   end

   // Outputs are registered from the next state so they line up with it exactly.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         cmd_ready  <= 1'b1;
         M_request  <= 1'b0;
         M_select   <= 1'b0;
         M_RNW      <= 1'b0;
         M_ABus     <= '0;
         M_BE       <= '0;
         M_DBus     <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= ST_OK;
      end else begin
         cmd_ready <= (state_d == S_IDLE);
         M_request <= (state_d == S_REQ);
         M_select  <= (state_d == S_XFER);
         rsp_valid <= (state_d == S_RESP);
         // Bus outputs stay zero unless selected so the OR-ed bus is not disturbed.
         M_RNW     <= (state_d == S_XFER) ? rnw_q : 1'b0;
         M_ABus    <= (state_d == S_XFER) ? addr_q : '0;
         M_BE      <= (state_d == S_XFER) ? be_q : '0;
         M_DBus    <= ((state_d == S_XFER) && !rnw_q) ? wdata_q : '0;
         if (load_rsp) begin
            rsp_rdata  <= rdata_d;
            rsp_status <= status_d;
         end
      end
   end

   assign M_busLock = 1'b0;
   assign M_seqAddr = 1'b0;
   assign dbg_state = state_q;

endmodule

// File: doc/opb_master_bridge.md
# opb_master_bridge

Single-outstanding OPB bus master that converts a simple command/response handshake from fabric logic into OPB read and write transactions. It is the initiator counterpart of the system-block OPB slaves. It arbitrates via request/grant, drives address, data and byte enables, and returns read data and a completion status. It sits between application logic on the OPB clock domain and the OPB arbiter/bus.

## Interface
- C_OPB_AWIDTH, 32, address width (bits 0..AWIDTH-1, bit 0 MSB)
- C_OPB_DWIDTH, 32, data width (bit 0 MSB)
- C_TIMEOUT, 255, XFER cycles without ack before local timeout (1..255)
- C_MAX_RETRY, 4, retries before giving up (1..15)

Ports:
- OPB_Clk  in  1  bus clock; only clock
- OPB_Rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_rnw  in  1  1=read, 0=write
- cmd_addr  in  [0:31]  byte address
- cmd_wdata  in  [0:31]  write data
- cmd_be  in  [0:3]  byte enables
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  [0:31]  read data (valid with rsp_valid, read only)
- rsp_status  out  2  00 ok, 01 errAck, 10 timeout, 11 retry exhausted
- M_request  out  1  bus request
- M_busLock  out  1  tied 0
- M_select  out  1  master owns bus
- M_RNW  out  1  transfer direction
- M_ABus  out  [0:31]  address
- M_BE  out  [0:3]  byte enables
- M_DBus  out  [0:31]  write data
- M_seqAddr  out  1  tied 0
- OPB_MGrant  in  1  grant from arbiter
- OPB_DBus  in  [0:31]  read data bus
- OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout  in  1 each  slave/bus termination

## Operation
- FSM states: IDLE, REQ, XFER, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register rnw/addr/wdata/be, clear retry count, -> REQ.
- REQ: M_request=1. OPB_MGrant sampled high -> XFER.
- XFER: M_select=1, M_request=0; M_ABus, M_BE, M_RNW driven from registers; M_DBus=wdata when write, else 0. Cycle counter increments each XFER cycle.
- XFER exits, priority order:
  - OPB_xferAck: capture OPB_DBus if read -> RESP; status 01 if OPB_errAck also high, else 00.
  - OPB_errAck alone: -> RESP, status 01.
  - OPB_retry: retry count +1. Count < C_MAX_RETRY -> REQ (counter cleared); otherwise -> RESP, status 11.
  - OPB_timeout, or counter reaching C_TIMEOUT: -> RESP, status 10.
- RESP: rsp_valid=1 one cycle -> IDLE. rsp_rdata/rsp_status hold until the next RESP.
- Outside XFER, M_ABus, M_BE, M_DBus and M_RNW are 0 (OR-bus rule). M_busLock and M_seqAddr are always 0.
- OPB_MGrant outside REQ is ignored. Termination inputs outside XFER are ignored.
- rsp_rdata is 0 after writes and after non-ok reads.

## Timing
- Reset (OPB_Rst_n low, asynchronous): state IDLE; all outputs 0 except cmd_ready=1; retry and timeout counters 0.
- Reset asserted mid-transaction: outputs drop immediately; no rsp_valid is issued for the aborted command.
- Outputs are registered, and the registers are updated on the clock edge following the decision.
- Best case: accept at edge 0; M_request high in cycle 1, with grant seen; M_select high in cycle 2, with xferAck seen; rsp_valid in cycle 3. This gives 3 cycles from accept to response.
- M_select drops in the cycle after termination; it never stays high for more than one cycle after ack.
- Retry path: M_select low for at least one cycle, then M_request re-asserts.
- cmd_ready is low from the accept cycle+1 until the cycle after rsp_valid.

## Test plan
- Write: addr 0x00000010, data 0xDEADBEEF, be 1111; grant after 2 cycles, xferAck on first XFER cycle -> M_ABus=0x10, M_DBus=0xDEADBEEF during select only; rsp_valid pulse, status 00.
- Read: addr 0x00000004; slave acks with OPB_DBus=0xB00B0100 after 3 XFER cycles -> rsp_rdata=0xB00B0100, status 00; M_DBus=0 throughout.
- Retry: slave asserts OPB_retry 3 times, then xferAck -> 3 re-requests and status 00. With retry asserted 4 times (C_MAX_RETRY=4) -> status 11, rsp_rdata=0.
- Timeout: no ack, C_TIMEOUT=8 -> select held 8 cycles then drops, status 10. Separately, OPB_timeout asserted in the 2nd XFER cycle -> status 10.
- Simultaneous events: xferAck+retry in the same cycle -> completes, status 00. xferAck+errAck in the same cycle -> status 01.
- Reset mid-XFER: OPB_Rst_n pulsed low while M_select=1 -> all bus outputs 0 immediately, no rsp_valid, cmd_ready=1; the next command completes normally.
